calc1_port_driver: RTL and testbench

CALC1_PORT_DRIVER -- requirements
Module: calc1_port_driver

---
 rtl/calc1_port_driver.sv | 158 +++++++++++++++
 tb/tb_calc1_port_driver.sv | 391 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/calc1_port_driver.sv
// Buffers upstream calculator requests in a small FIFO and issues them one at a time to a
// calculator port, returning either the calculator's response or a timeout result.
module calc1_port_driver #(
   parameter int FIFO_DEPTH = 4,
   parameter int TIMEOUT    = 16
) (
   input  logic        c_clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [3:0]  req_cmd,
   input  logic [31:0] req_op1,
   input  logic [31:0] req_op2,
   output logic [3:0]  calc_cmd,
   output logic [31:0] calc_data,
   input  logic [1:0]  calc_resp,
   input  logic [31:0] calc_rdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [1:0]  rsp_resp,
   output logic [31:0] rsp_data,
   output logic        rsp_timeout,
   output logic        spurious
);
   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [2:0] {IDLE, ISSUE_CMD, ISSUE_DATA, WAIT, RESULT} state_t;

   state_t        r_state;
   logic [3:0]    r_fifoCmd [FIFO_DEPTH];
   logic [31:0]   r_fifoOp1 [FIFO_DEPTH];
   logic [31:0]   r_fifoOp2 [FIFO_DEPTH];
   logic [PW-1:0] r_wrPtr;
   logic [PW-1:0] r_rdPtr;
   logic [CW-1:0] r_count;
   logic          r_readyEn;
   logic [TW-1:0] r_timer;
   logic [31:0]   r_op2;
   logic [3:0]    r_calcCmd;
   logic [31:0]   r_calcData;
   logic          r_rspValid;
   logic [1:0]    r_rspResp;
   logic [31:0]   r_rspData;
   logic          r_rspTimeout;
   logic          r_spurious;

   logic          w_push;
   logic          w_pop;
   logic [3:0]    w_headCmd;

   // r_readyEn holds req_ready low through reset and the first edge after release.
   assign req_ready = r_readyEn && (r_count != CW'(FIFO_DEPTH));
   assign w_push    = req_valid && req_ready;
   assign w_pop     = (r_state == IDLE) && (r_count != '0);
   assign w_headCmd = r_fifoCmd[r_rdPtr];

   always_ff @(posedge c_clk) begin
      if (w_push) begin
         r_fifoCmd[r_wrPtr] <= req_cmd;
         r_fifoOp1[r_wrPtr] <= req_op1;
         r_fifoOp2[r_wrPtr] <= req_op2;
      end
   end

   always_ff @(posedge c_clk or negedge reset) begin
      if (!reset) begin
         r_wrPtr   <= '0;
         r_rdPtr   <= '0;
         r_count   <= '0;
         r_readyEn <= 1'b0;
      end else begin
         r_readyEn <= 1'b1;
         if (w_push) r_wrPtr <= r_wrPtr + PW'(1);
         if (w_pop)  r_rdPtr <= r_rdPtr + PW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge c_clk or negedge reset) begin
      if (!reset) begin
         r_state      <= IDLE;
         r_timer      <= '0;
         r_op2        <= '0;
         r_calcCmd    <= '0;
         r_calcData   <= '0;
         r_rspValid   <= 1'b0;
         r_rspResp    <= '0;
         r_rspData    <= '0;
         r_rspTimeout <= 1'b0;
         r_spurious   <= 1'b0;
      end else begin
         if ((calc_resp != 2'd0) && (r_state != WAIT)) r_spurious <= 1'b1;
         case (r_state)
            IDLE: begin
               r_calcCmd  <= '0;
               r_calcData <= '0;
               // A popped zero command is simply dropped.
               if (w_pop && (w_headCmd != 4'd0)) begin
                  r_calcCmd  <= w_headCmd;
                  r_calcData <= r_fifoOp1[r_rdPtr];
                  r_op2      <= r_fifoOp2[r_rdPtr];
                  r_state    <= ISSUE_CMD;
               end
            end
            ISSUE_CMD: begin
               r_calcCmd  <= '0;
               r_calcData <= r_op2;
               r_state    <= ISSUE_DATA;
            end
            ISSUE_DATA: begin
               r_calcCmd  <= '0;
               r_calcData <= '0;
               r_timer    <= '0;
               r_state    <= WAIT;
            end
            WAIT: begin
               if (calc_resp != 2'd0) begin
                  r_rspResp    <= calc_resp;
                  r_rspData    <= calc_rdata;
                  r_rspTimeout <= 1'b0;
                  r_rspValid   <= 1'b1;
                  r_state      <= RESULT;
               end else if (r_timer == TW'(TIMEOUT - 1)) begin
                  r_rspResp    <= '0;
                  r_rspData    <= '0;
                  r_rspTimeout <= 1'b1;
                  r_rspValid   <= 1'b1;
                  r_state      <= RESULT;
               end else begin
                  r_timer <= r_timer + TW'(1);
               end
            end
            RESULT: begin
               if (rsp_ready) begin
                  r_rspValid <= 1'b0;
                  r_state    <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign calc_cmd    = r_calcCmd;
   assign calc_data   = r_calcData;
   assign rsp_valid   = r_rspValid;
   assign rsp_resp    = r_rspResp;
   assign rsp_data    = r_rspData;
   assign rsp_timeout = r_rspTimeout;
   assign spurious    = r_spurious;

endmodule

// File: tb/tb_calc1_port_driver.sv
// Testbench for calc1_port_driver: the bench plays both the upstream requester and the
// calculator, and predicts issue order, timing and results from the request stream.
module tb_calc1_port_driver;
   localparam int FIFO_DEPTH = 4;
   localparam int TIMEOUT    = 16;
   localparam int RN         = 30;

   logic        c_clk;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic [3:0]  req_cmd;
   logic [31:0] req_op1;
   logic [31:0] req_op2;
   logic [3:0]  calc_cmd;
   logic [31:0] calc_data;
   logic [1:0]  calc_resp;
   logic [31:0] calc_rdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [1:0]  rsp_resp;
   logic [31:0] rsp_data;
   logic        rsp_timeout;
   logic        spurious;

   int errors = 0;
   int checks = 0;

   calc1_port_driver #(.FIFO_DEPTH(FIFO_DEPTH), .TIMEOUT(TIMEOUT)) dut (
      .c_clk(c_clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_cmd(req_cmd), .req_op1(req_op1), .req_op2(req_op2),
      .calc_cmd(calc_cmd), .calc_data(calc_data),
      .calc_resp(calc_resp), .calc_rdata(calc_rdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_resp(rsp_resp), .rsp_data(rsp_data),
      .rsp_timeout(rsp_timeout), .spurious(spurious)
   );

   always #5 c_clk = ~c_clk;

   // Called just after a falling edge; returns just after the falling edge that follows the push.
   task automatic pushOne(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                          output bit ok);
      int w;
      w = 0;
      while (req_ready !== 1'b1 && w < 100) begin
         @(negedge c_clk);
         w++;
      end
      ok = (req_ready === 1'b1);
      if (ok) begin
         req_valid = 1'b1;
         req_cmd   = c;
         req_op1   = a;
         req_op2   = b;
         @(negedge c_clk);
         req_valid = 1'b0;
      end
   endtask

   task automatic test_reset();
      repeat (2) @(negedge c_clk);
      checks++;
      if (req_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready: got %b expected 0", req_ready); end
      checks++;
      if ({calc_cmd, calc_data} !== 36'd0) begin errors++; $display("[TB] FAIL reset_calc: got %h expected 0", {calc_cmd, calc_data}); end
      checks++;
      if ({rsp_valid, rsp_resp, rsp_data, rsp_timeout, spurious} !== 37'd0) begin
         errors++; $display("[TB] FAIL reset_rsp: got %h expected 0", {rsp_valid, rsp_resp, rsp_data, rsp_timeout, spurious});
      end
      reset = 1'b1;
      @(negedge c_clk);
      checks++;
      if (req_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_release_ready: got %b expected 1", req_ready); end
   endtask

   task automatic test_add();
      bit ok;
      pushOne(4'd1, 32'd5, 32'd7, ok);
      checks++;
      if (!ok) begin errors++; $display("[TB] FAIL add_push: got not-ready expected ready"); end
      @(negedge c_clk);
      checks++;
      if (calc_cmd !== 4'd1 || calc_data !== 32'd5) begin
         errors++; $display("[TB] FAIL add_issue_cmd: got %0d/%0d expected 1/5", calc_cmd, calc_data);
      end
      @(negedge c_clk);
      checks++;
      if (calc_cmd !== 4'd0 || calc_data !== 32'd7) begin
         errors++; $display("[TB] FAIL add_issue_data: got %0d/%0d expected 0/7", calc_cmd, calc_data);
      end
      @(negedge c_clk);
      checks++;
      if (calc_cmd !== 4'd0 || calc_data !== 32'd0 || rsp_valid !== 1'b0) begin
         errors++; $display("[TB] FAIL add_wait: got %0d/%0d/%b expected 0/0/0", calc_cmd, calc_data, rsp_valid);
      end
      calc_resp  = 2'd1;
      calc_rdata = 32'd12;
      @(negedge c_clk);
      calc_resp  = 2'd0;
      calc_rdata = 32'd0;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_resp !== 2'd1 || rsp_data !== 32'd12 || rsp_timeout !== 1'b0) begin
         errors++; $display("[TB] FAIL add_rsp: got v=%b r=%0d d=%0d t=%b expected 1/1/12/0", rsp_valid, rsp_resp, rsp_data, rsp_timeout);
      end
      @(negedge c_clk);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== 32'd12) begin
         errors++; $display("[TB] FAIL add_hold: got v=%b d=%0d expected 1/12", rsp_valid, rsp_data);
      end
      rsp_ready = 1'b1;
      @(negedge c_clk);
      rsp_ready = 1'b0;
      checks++;
      if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL add_accept: got %b expected 0", rsp_valid); end
   endtask

   task automatic test_invalid();
      bit ok;
      pushOne(4'd3, 32'd1, 32'd1, ok);
      checks++;
      if (!ok) begin errors++; $display("[TB] FAIL inv_push: got not-ready expected ready"); end
      @(negedge c_clk);
      checks++;
      if (calc_cmd !== 4'd3 || calc_data !== 32'd1) begin
         errors++; $display("[TB] FAIL inv_issue: got %0d/%0d expected 3/1", calc_cmd, calc_data);
      end
      @(negedge c_clk);
      repeat (3) @(negedge c_clk);
      calc_resp  = 2'd2;
      calc_rdata = 32'hDEAD_0003;
      @(negedge c_clk);
      calc_resp  = 2'd0;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_resp !== 2'd2 || rsp_timeout !== 1'b0 || rsp_data !== 32'hDEAD_0003) begin
         errors++; $display("[TB] FAIL inv_rsp: got v=%b r=%0d t=%b d=%h expected 1/2/0/dead0003", rsp_valid, rsp_resp, rsp_timeout, rsp_data);
      end
      rsp_ready = 1'b1;
      @(negedge c_clk);
      rsp_ready = 1'b0;
   endtask

   task automatic test_nop();
      bit ok1, ok2;
      int cmdSeen, rspSeen, issueAt;
      logic [3:0]  lastCmd;
      logic [31:0] gotData;
      cmdSeen = 0; rspSeen = 0; issueAt = -100; lastCmd = '0; gotData = '0;
      rsp_ready = 1'b1;
      pushOne(4'd0, 32'd9, 32'd9, ok1);
      pushOne(4'd2, 32'd3, 32'd10, ok2);
      checks++;
      if (!(ok1 && ok2)) begin errors++; $display("[TB] FAIL nop_push: got %b%b expected 11", ok1, ok2); end
      for (int i = 0; i < 40; i++) begin
         @(negedge c_clk);
         if (calc_cmd !== 4'd0) begin cmdSeen++; lastCmd = calc_cmd; issueAt = i; end
         if (rsp_valid === 1'b1) begin rspSeen++; gotData = rsp_data; end
         calc_resp  = (cmdSeen == 1 && i == issueAt + 2) ? 2'd1 : 2'd0;
         calc_rdata = (cmdSeen == 1 && i == issueAt + 2) ? 32'd7 : 32'd0;
      end
      rsp_ready = 1'b0;
      checks++;
      if (cmdSeen != 1 || lastCmd !== 4'd2) begin
         errors++; $display("[TB] FAIL nop_issue: got %0d issues last=%0d expected 1 issue of 2", cmdSeen, lastCmd);
      end
      checks++;
      if (rspSeen != 1 || gotData !== 32'd7) begin
         errors++; $display("[TB] FAIL nop_rsp: got %0d rsp data=%0d expected 1 rsp data=7", rspSeen, gotData);
      end
   endtask

   task automatic test_backpressure();
      logic [3:0]  bpCmd [5];
      logic [31:0] bpOp1 [5];
      bit ok;
      int issueCyc, nTo, nIss, cyc;
      logic [3:0] legal [4];
      legal[0] = 4'd1; legal[1] = 4'd2; legal[2] = 4'd5; legal[3] = 4'd6;
      for (int i = 0; i < 5; i++) begin
         bpCmd[i] = legal[$urandom_range(0, 3)];
         bpOp1[i] = $urandom;
      end
      issueCyc = 0; nTo = 0; nIss = 0; cyc = 0;
      rsp_ready = 1'b1;
      fork
         begin
            // The first request goes in flight at once, so five pushes leave four queued.
            for (int i = 0; i < 5; i++) begin
               pushOne(bpCmd[i], bpOp1[i], $urandom, ok);
               checks++;
               if (!ok) begin errors++; $display("[TB] FAIL bp_push%0d: got not-ready expected ready", i); end
            end
            checks++;
            if (req_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_full: got %b expected 0", req_ready); end
         end
         begin
            while (nTo < 5 && cyc < 5 * (TIMEOUT + 10)) begin
               @(negedge c_clk);
               cyc++;
               if (calc_cmd !== 4'd0) begin
                  issueCyc = cyc;
                  checks++;
                  if (nIss >= 5 || calc_cmd !== bpCmd[nIss] || calc_data !== bpOp1[nIss]) begin
                     errors++; $display("[TB] FAIL bp_issue%0d: got %0d/%h expected %0d/%h", nIss, calc_cmd, calc_data,
                                        bpCmd[nIss % 5], bpOp1[nIss % 5]);
                  end
                  nIss++;
               end
               if (rsp_valid === 1'b1) begin
                  checks++;
                  if (rsp_timeout !== 1'b1 || rsp_resp !== 2'd0 || rsp_data !== 32'd0 || cyc - issueCyc != TIMEOUT + 2) begin
                     errors++; $display("[TB] FAIL bp_timeout%0d: got t=%b r=%0d d=%0d wait=%0d expected 1/0/0/%0d",
                                        nTo, rsp_timeout, rsp_resp, rsp_data, cyc - issueCyc - 2, TIMEOUT);
                  end
                  nTo++;
               end
            end
            checks++;
            if (nTo != 5) begin errors++; $display("[TB] FAIL bp_count: got %0d timeouts expected 5", nTo); end
         end
      join
      @(negedge c_clk);
      rsp_ready = 1'b0;
   endtask

   task automatic test_random();
      logic [3:0]  rc [RN];
      logic [31:0] ra [RN];
      logic [31:0] rb [RN];
      int expIdx [$];
      bit ok, respond;
      int idx, w, d, lat, hold;
      logic [1:0]  eResp;
      logic [31:0] eData;
      for (int i = 0; i < RN; i++) begin
         rc[i] = ($urandom_range(0, 4) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
         ra[i] = $urandom;
         rb[i] = $urandom;
         if (rc[i] != 4'd0) expIdx.push_back(i);
      end
      fork
         begin
            for (int i = 0; i < RN; i++) begin
               repeat ($urandom_range(0, 3)) @(negedge c_clk);
               pushOne(rc[i], ra[i], rb[i], ok);
               checks++;
               if (!ok) begin errors++; $display("[TB] FAIL rnd_push%0d: got not-ready expected ready", i); break; end
            end
         end
         begin
            while (expIdx.size() > 0) begin
               idx = expIdx.pop_front();
               w = 0;
               while (calc_cmd === 4'd0 && w < 300) begin @(negedge c_clk); w++; end
               checks++;
               if (calc_cmd !== rc[idx] || calc_data !== ra[idx]) begin
                  errors++; $display("[TB] FAIL rnd_issue%0d: got %0d/%h expected %0d/%h", idx, calc_cmd, calc_data, rc[idx], ra[idx]);
                  break;
               end
               @(negedge c_clk);
               checks++;
               if (calc_cmd !== 4'd0 || calc_data !== rb[idx]) begin
                  errors++; $display("[TB] FAIL rnd_data%0d: got %0d/%h expected 0/%h", idx, calc_cmd, calc_data, rb[idx]);
               end
               d = $urandom_range(0, TIMEOUT + 2);
               respond = (d < TIMEOUT);
               lat = respond ? d : TIMEOUT - 1;
               eResp = respond ? 2'($urandom_range(1, 3)) : 2'd0;
               eData = respond ? $urandom : 32'd0;
               for (int k = 0; k <= lat; k++) begin
                  @(negedge c_clk);
                  checks++;
                  if (rsp_valid !== 1'b0 || calc_cmd !== 4'd0 || calc_data !== 32'd0) begin
                     errors++; $display("[TB] FAIL rnd_wait%0d: got v=%b cmd=%0d data=%h at wait %0d expected 0/0/0", idx, rsp_valid, calc_cmd, calc_data, k);
                  end
                  if (respond && k == d) begin calc_resp = eResp; calc_rdata = eData; end
               end
               @(negedge c_clk);
               calc_resp = 2'd0;
               calc_rdata = 32'd0;
               hold = $urandom_range(0, 2);
               for (int h = 0; h <= hold; h++) begin
                  checks++;
                  if (rsp_valid !== 1'b1 || rsp_resp !== eResp || rsp_data !== eData || rsp_timeout !== (respond ? 1'b0 : 1'b1)) begin
                     errors++; $display("[TB] FAIL rnd_rsp%0d: got v=%b r=%0d d=%h t=%b expected 1/%0d/%h/%b", idx,
                                        rsp_valid, rsp_resp, rsp_data, rsp_timeout, eResp, eData, !respond);
                  end
                  if (h < hold) @(negedge c_clk);
               end
               rsp_ready = 1'b1;
               @(negedge c_clk);
               rsp_ready = 1'b0;
               checks++;
               if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL rnd_accept%0d: got %b expected 0", idx, rsp_valid); end
            end
         end
      join
      checks++;
      if (spurious !== 1'b0) begin errors++; $display("[TB] FAIL rnd_spurious: got %b expected 0", spurious); end
   endtask

   task automatic test_spurious();
      bit ok;
      calc_resp = 2'd1;
      @(negedge c_clk);
      calc_resp = 2'd0;
      checks++;
      if (spurious !== 1'b1 || rsp_valid !== 1'b0) begin
         errors++; $display("[TB] FAIL spur_set: got s=%b v=%b expected 1/0", spurious, rsp_valid);
      end
      pushOne(4'd6, 32'h80, 32'd2, ok);
      @(negedge c_clk);
      checks++;
      if (!ok || calc_cmd !== 4'd6 || calc_data !== 32'h80) begin
         errors++; $display("[TB] FAIL spur_issue: got %0d/%h expected 6/80", calc_cmd, calc_data);
      end
      repeat (2) @(negedge c_clk);
      calc_resp  = 2'd1;
      calc_rdata = 32'h20;
      @(negedge c_clk);
      calc_resp  = 2'd0;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== 32'h20 || spurious !== 1'b1) begin
         errors++; $display("[TB] FAIL spur_sticky: got v=%b d=%h s=%b expected 1/20/1", rsp_valid, rsp_data, spurious);
      end
      rsp_ready = 1'b1;
      @(negedge c_clk);
      rsp_ready = 1'b0;
   endtask

   task automatic test_reset_in_wait();
      bit ok1, ok2;
      int issued, rsps;
      issued = 0; rsps = 0;
      pushOne(4'd1, 32'd4, 32'd4, ok1);
      pushOne(4'd2, 32'd8, 32'd1, ok2);
      repeat (2) @(negedge c_clk);
      #2 reset = 1'b0;
      #1;
      checks++;
      if (req_ready !== 1'b0 || {calc_cmd, calc_data} !== 36'd0) begin
         errors++; $display("[TB] FAIL rstw_calc: got rdy=%b %h expected 0/0", req_ready, {calc_cmd, calc_data});
      end
      checks++;
      if ({rsp_valid, rsp_resp, rsp_data, rsp_timeout, spurious} !== 37'd0) begin
         errors++; $display("[TB] FAIL rstw_rsp: got %h expected 0", {rsp_valid, rsp_resp, rsp_data, rsp_timeout, spurious});
      end
      @(negedge c_clk);
      reset = 1'b1;
      for (int i = 0; i < 30; i++) begin
         @(negedge c_clk);
         if (i == 0) begin
            checks++;
            if (!(ok1 && ok2) || req_ready !== 1'b1) begin
               errors++; $display("[TB] FAIL rstw_ready: got %b expected 1", req_ready);
            end
         end
         if (calc_cmd !== 4'd0) issued++;
         if (rsp_valid !== 1'b0) rsps++;
      end
      checks++;
      if (issued != 0 || rsps != 0) begin
         errors++; $display("[TB] FAIL rstw_quiet: got %0d issues %0d rsps expected 0/0", issued, rsps);
      end
   endtask

   initial begin
      c_clk = 1'b0; reset = 1'b1;
      req_valid = 1'b0; req_cmd = '0; req_op1 = '0; req_op2 = '0;
      calc_resp = '0; calc_rdata = '0; rsp_ready = 1'b0;
      #1 reset = 1'b0;
      test_reset();
      test_add();
      test_invalid();
      test_nop();
      test_backpressure();
      test_random();
      test_spurious();
      test_reset_in_wait();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: got no completion expected finish before 1ms");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
